// File: rtl/spc_node_decoder_seq.sv
// Multi-beat SPC node decoder for the fast-SSC polar decoder.
// Collects hard bits, parity and min |LLR|, fixes parity, streams bits out.
module spc_node_decoder_seq #(
    parameter int LLR_W     = 6,
    parameter int P         = 16,
    parameter int MAX_BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P*LLR_W-1:0]   in_llr,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P-1:0]         out_bits,
    output logic                 out_last,
    output logic                 out_flip,
    output logic [LLR_W-2:0]     out_min
);

    localparam int NODE_LEN = P * MAX_BEATS;
    localparam int IDX_W    = (NODE_LEN > 1) ? $clog2(NODE_LEN) : 1;
    localparam int MAG_W    = LLR_W - 1;
    localparam int BW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam int LW       = (P > 1) ? $clog2(P) : 1;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        FIX = 2'd1,
        OUT = 2'd2
    } state_t;

    state_t             state;
    logic [BW-1:0]      beat_cnt;
    logic [BW-1:0]      out_cnt;
    logic [BW-1:0]      last_beat;
    logic               parity;
    logic [MAG_W-1:0]   run_min;
    logic [IDX_W-1:0]   run_idx;
    logic [P-1:0]       bits_buf [MAX_BEATS];

    logic [P-1:0]       beat_bits;
    logic               beat_par;
    logic [MAG_W-1:0]   beat_min;
    logic [LW-1:0]      beat_lane;
    logic [IDX_W-1:0]   beat_idx;
    logic [BW-1:0]      flip_beat;
    logic [LW-1:0]      flip_lane;

    // Magnitude with the most-negative code clamped to the largest positive.
    function automatic logic [MAG_W-1:0] abs_sat(input logic [LLR_W-1:0] v);
        logic [LLR_W-1:0] n;
        n = -v;
        if (!v[LLR_W-1])
            return v[MAG_W-1:0];
        if (n[LLR_W-1])
            return '1;
        return n[MAG_W-1:0];
    endfunction

    // Per-beat hard bits, parity and first-occurring minimum magnitude.
    always_comb begin
        beat_bits = '0;
        beat_par  = 1'b0;
        beat_min  = '1;
        beat_lane = '0;
        for (int k = 0; k < P; k++) begin
            logic [LLR_W-1:0] lv;
            logic [MAG_W-1:0] mag;
            lv           = in_llr[k*LLR_W +: LLR_W];
            mag          = abs_sat(lv);
            beat_bits[k] = lv[LLR_W-1];
            beat_par     = beat_par ^ lv[LLR_W-1];
            if (k == 0 || mag < beat_min) begin
                beat_min  = mag;
                beat_lane = LW'(k);
            end
        end
    end

    assign beat_idx  = IDX_W'(32'(beat_cnt) * P + 32'(beat_lane));
    assign flip_beat = BW'(32'(run_idx) / P);
    assign flip_lane = LW'(32'(run_idx) % P);

    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);
    assign out_last  = (state == OUT) && (out_cnt == last_beat);
    assign out_bits  = (state == OUT) ? bits_buf[out_cnt] : '0;

    // Node FSM: accumulate beats, fix parity in one cycle, then stream out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            beat_cnt  <= '0;
            out_cnt   <= '0;
            last_beat <= '0;
            parity    <= 1'b0;
            run_min   <= '1;
            run_idx   <= '0;
            out_flip  <= 1'b0;
            out_min   <= '1;
            for (int b = 0; b < MAX_BEATS; b++)
                bits_buf[b] <= '0;
        end else begin
            unique case (state)
                ACC: begin
                    if (in_valid) begin
                        bits_buf[beat_cnt] <= beat_bits;
                        parity <= parity ^ beat_par;
                        if (beat_min < run_min) begin
                            run_min <= beat_min;
                            run_idx <= beat_idx;
                        end
                        if (in_last || beat_cnt == BW'(MAX_BEATS - 1)) begin
                            last_beat <= beat_cnt;
                            state     <= FIX;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                FIX: begin
                    if (parity)
                        bits_buf[flip_beat][flip_lane] <=
                            ~bits_buf[flip_beat][flip_lane];
                    out_flip <= parity;
                    out_min  <= run_min;
                    state    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_cnt == last_beat) begin
                            beat_cnt <= '0;
                            out_cnt  <= '0;
                            parity   <= 1'b0;
                            run_min  <= '1;
                            run_idx  <= '0;
                            state    <= ACC;
                        end else begin
                            out_cnt <= out_cnt + BW'(1);
                        end
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
